// File: rtl/bounce_generator.sv
// bounce_generator: turns a clean level command into a pseudo-random bouncy contact signal.
// Optional macro BOUNCE_GEN_COUNT_EN adds the o_Edge_Count burst toggle counter.
module bounce_generator #(
  parameter int unsigned BOUNCE_CYCLES = 16,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned SEG_BITS      = 2,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Level,
  output logic       o_Bouncy,
  output logic       o_Busy,
  output logic       o_Done
`ifdef BOUNCE_GEN_COUNT_EN
  ,
  output logic [7:0] o_Edge_Count
`endif
);

  localparam int unsigned WIN_W = $clog2(BOUNCE_CYCLES + 1);
  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [15:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
  localparam logic [WIN_W-1:0] WIN_INIT = WIN_W'(BOUNCE_CYCLES - 1);
  localparam logic [SET_W-1:0] SET_INIT = SET_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BOUNCE = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  // Galois step, shifting right; an all-zero seed never reaches here.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_MASK : 16'h0000);
  endfunction

  state_t              state_q, state_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic                target_q, target_d;
  logic                bouncy_q, bouncy_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [WIN_W-1:0]    window_q, window_d;
  logic [SET_W-1:0]    settle_q, settle_d;
  logic [SEG_BITS-1:0] seg_q, seg_d;
  logic                start_s;

  // A retarget during BOUNCE restarts the window; SETTLE deliberately ignores the input.
  assign start_s = ((state_q == ST_IDLE) || (state_q == ST_BOUNCE)) && (i_Level != target_q);

  // Next-state and next-output computation for the burst sequencer.
  always_comb begin
    lfsr_d   = lfsr_next(lfsr_q);
    state_d  = state_q;
    target_d = target_q;
    bouncy_d = bouncy_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    window_d = window_q;
    settle_d = settle_q;
    seg_d    = seg_q;
    if (start_s) begin
      target_d = i_Level;
      bouncy_d = i_Level;
      window_d = WIN_INIT;
      seg_d    = lfsr_q[SEG_BITS-1:0];
      busy_d   = 1'b1;
      state_d  = ST_BOUNCE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          busy_d = 1'b0;
        end
        ST_BOUNCE: begin
          if (window_q == WIN_W'(0)) begin
            bouncy_d = target_q;
            settle_d = SET_INIT;
            state_d  = ST_SETTLE;
          end else begin
            window_d = window_q - WIN_W'(1);
            if (seg_q == SEG_BITS'(0)) begin
              bouncy_d = ~bouncy_q;
              seg_d    = lfsr_q[SEG_BITS-1:0];
            end else begin
              seg_d = seg_q - SEG_BITS'(1);
            end
          end
        end
        ST_SETTLE: begin
          bouncy_d = target_q;
          if (settle_q == SET_W'(0)) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            settle_d = settle_q - SET_W'(1);
          end
        end
        default: begin
          state_d  = ST_IDLE;
          busy_d   = 1'b0;
          bouncy_d = target_q;
        end
      endcase
    end
  end

  // State and output registers; reset aborts any burst in progress.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q  <= ST_IDLE;
      lfsr_q   <= SEED_EFF;
      target_q <= 1'b0;
      bouncy_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      window_q <= WIN_W'(0);
      settle_q <= SET_W'(0);
      seg_q    <= SEG_BITS'(0);
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      target_q <= target_d;
      bouncy_q <= bouncy_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      window_q <= window_d;
      settle_q <= settle_d;
      seg_q    <= seg_d;
    end
  end

  assign o_Bouncy = bouncy_q;
  assign o_Busy   = busy_q;
  assign o_Done   = done_q;

`ifdef BOUNCE_GEN_COUNT_EN
  logic [7:0] edge_count_q, edge_count_d;
  logic       toggle_s;

  assign toggle_s = !start_s && (state_q == ST_BOUNCE) && (window_q != WIN_W'(0)) &&
                    (seg_q == SEG_BITS'(0));

  // Burst toggle counter: first contact counts as one, saturates, holds until the next start.
  always_comb begin
    if (start_s) begin
      edge_count_d = 8'd1;
    end else if (toggle_s && (edge_count_q != 8'hFF)) begin
      edge_count_d = edge_count_q + 8'd1;
    end else begin
      edge_count_d = edge_count_q;
    end
  end

  // Edge counter register.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      edge_count_q <= 8'd0;
    end else begin
      edge_count_q <= edge_count_d;
    end
  end

  assign o_Edge_Count = edge_count_q;
`endif

endmodule

// File: tb/tb_bounce_generator.sv
// Self-checking bench for bounce_generator: edge-indexed burst model plus directed scenarios.
module tb_bounce_generator;

  localparam int B = 16;
  localparam int S = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic level;
  logic bouncy_a, busy_a, done_a;
  logic bouncy_b, busy_b, done_b;
`ifdef BOUNCE_GEN_COUNT_EN
  logic [7:0] cnt_a, cnt_b;
`endif

  always #5 clk = ~clk;

  bounce_generator #(.BOUNCE_CYCLES(B), .SETTLE_CYCLES(S), .SEG_BITS(2), .LFSR_SEED(16'hACE1)) dut_a (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Level(level),
    .o_Bouncy(bouncy_a), .o_Busy(busy_a), .o_Done(done_a)
`ifdef BOUNCE_GEN_COUNT_EN
    , .o_Edge_Count(cnt_a)
`endif
  );

  // Seed 0 must behave exactly like the default seed.
  bounce_generator #(.BOUNCE_CYCLES(B), .SETTLE_CYCLES(S), .SEG_BITS(2), .LFSR_SEED(16'h0000)) dut_b (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Level(level),
    .o_Bouncy(bouncy_b), .o_Busy(busy_b), .o_Done(done_b)
`ifdef BOUNCE_GEN_COUNT_EN
    , .o_Edge_Count(cnt_b)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: burst described by edge index k since the start edge and the next scheduled toggle edge.
  logic [15:0] m_lfsr;
  int          m_mode;
  int          m_k, m_next, m_cnt;
  logic        m_tgt, m_bouncy, m_busy, m_done;

  // Downstream debounce filters (limit 4), one on the DUT output and one on the model output.
  logic fa_st, fm_st;
  int   fa_cnt, fm_cnt, fa_rises, fm_rises;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_lfsr = 16'hACE1;
    m_mode = 0;
    m_k = 0; m_next = 0; m_cnt = 0;
    m_tgt = 1'b0; m_bouncy = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    fa_st = 1'b0; fm_st = 1'b0; fa_cnt = 0; fm_cnt = 0;
  endtask

  task automatic model_start(input logic [15:0] lf, input logic lvl);
    m_tgt = lvl; m_bouncy = lvl; m_k = 0;
    m_next = int'(lf[1:0]) + 1;
    m_busy = 1'b1; m_cnt = 1; m_mode = 1;
  endtask

  task automatic model_edge(input logic lvl);
    logic [15:0] lf;
    lf = m_lfsr;
    m_lfsr = lfsr_step(m_lfsr);
    m_done = 1'b0;
    if (m_mode == 0) begin
      if (lvl !== m_tgt) model_start(lf, lvl);
    end else if (m_mode == 1) begin
      m_k++;
      if (lvl !== m_tgt) model_start(lf, lvl);
      else if (m_k == B) begin
        m_bouncy = m_tgt; m_mode = 2;
      end else if (m_k == m_next) begin
        m_bouncy = ~m_bouncy;
        if (m_cnt < 255) m_cnt++;
        m_next = m_k + int'(lf[1:0]) + 1;
      end
    end else begin
      m_k++;
      if (m_k == B + S) begin
        m_mode = 0; m_busy = 1'b0; m_done = 1'b1;
      end
    end
  endtask

  task automatic filt(input logic x, input logic st, input int c, output logic st_n, output int c_n);
    st_n = st;
    if ((x !== st) && (c < 3)) c_n = c + 1;
    else if (c == 3) begin st_n = x; c_n = 0; end
    else c_n = 0;
  endtask

  task automatic compare_all();
    check("bouncy_a", {31'd0, bouncy_a}, {31'd0, m_bouncy});
    check("busy_a",   {31'd0, busy_a},   {31'd0, m_busy});
    check("done_a",   {31'd0, done_a},   {31'd0, m_done});
    check("bouncy_b", {31'd0, bouncy_b}, {31'd0, m_bouncy});
    check("busy_b",   {31'd0, busy_b},   {31'd0, m_busy});
    check("done_b",   {31'd0, done_b},   {31'd0, m_done});
`ifdef BOUNCE_GEN_COUNT_EN
    check("edge_cnt_a", {24'd0, cnt_a}, m_cnt);
    check("edge_cnt_b", {24'd0, cnt_b}, m_cnt);
`endif
  endtask

  // One clock: drive level, run the filters on pre-edge outputs, advance model, compare after the edge.
  task automatic step(input logic lvl);
    logic ns; int nc;
    level = lvl;
    filt(bouncy_a, fa_st, fa_cnt, ns, nc);
    if (ns && !fa_st) fa_rises++;
    fa_st = ns; fa_cnt = nc;
    filt(m_bouncy, fm_st, fm_cnt, ns, nc);
    if (ns && !fm_st) fm_rises++;
    fm_st = ns; fm_cnt = nc;
    @(posedge clk);
    model_edge(lvl);
    #1;
    compare_all();
  endtask

  task automatic check_reset_lits(input string tag);
    check({tag, "_bouncy"}, {31'd0, bouncy_a}, 32'd0);
    check({tag, "_busy"},   {31'd0, busy_a},   32'd0);
    check({tag, "_done"},   {31'd0, done_a},   32'd0);
  endtask

  initial begin
    fa_rises = 0; fm_rises = 0;
    rst_n = 1'b0;
    level = 1'b0;
    model_reset();
    #2;
    check_reset_lits("rst_noclk");
    @(posedge clk); #1;
    check_reset_lits("rst_held");
    rst_n = 1'b1;

    // Pin the model's LFSR against hand-computed values.
    check("lfsr_pin1", {16'd0, lfsr_step(16'hACE1)}, 32'h0000E270);
    check("lfsr_pin2", {16'd0, lfsr_step(16'hE270)}, 32'h00007138);
    check("lfsr_pin3", {16'd0, lfsr_step(16'h7138)}, 32'h0000389C);

    // Quiet input after reset: nothing happens.
    for (int i = 0; i < 50; i++) begin
      step(1'b0);
      check("idle_busy", {31'd0, busy_a}, 32'd0);
      check("idle_bouncy", {31'd0, bouncy_a}, 32'd0);
    end

    // Default burst 0->1.
    step(1'b1);
    check("e0_bouncy", {31'd0, bouncy_a}, 32'd1);
    check("e0_busy", {31'd0, busy_a}, 32'd1);
    for (int e = 1; e <= B + S; e++) begin
      step(1'b1);
      if (e >= B) check("hold_bouncy", {31'd0, bouncy_a}, 32'd1);
      if (e == B + S) begin
        check("done_pulse", {31'd0, done_a}, 32'd1);
        check("busy_release", {31'd0, busy_a}, 32'd0);
      end else begin
        check("busy_during", {31'd0, busy_a}, 32'd1);
        check("no_early_done", {31'd0, done_a}, 32'd0);
      end
    end
    step(1'b1);
    check("done_single", {31'd0, done_a}, 32'd0);

    // Return to 0 and let it finish.
    for (int i = 0; i < B + S + 2; i++) step(1'b0);
    check("back_to_0", {31'd0, bouncy_a}, 32'd0);

    // Retarget: 0->1, back to 0 sampled at E5.
    step(1'b1);
    for (int e = 1; e <= 4; e++) step(1'b1);
    step(1'b0);
    check("retarget_bouncy", {31'd0, bouncy_a}, 32'd0);
    check("retarget_busy", {31'd0, busy_a}, 32'd1);
    for (int j = 1; j <= B + S; j++) begin
      step(1'b0);
      if (j >= B) check("retarget_hold", {31'd0, bouncy_a}, 32'd0);
      if (j == B + S) check("retarget_done", {31'd0, done_a}, 32'd1);
      else check("retarget_no_done", {31'd0, done_a}, 32'd0);
    end

    // Level drop during SETTLE is ignored, then picked up the edge after done.
    step(1'b1);
    for (int e = 1; e <= B; e++) step(1'b1);
    for (int e = B + 1; e <= B + S; e++) begin
      step(1'b0);
      check("settle_ignore", {31'd0, bouncy_a}, 32'd1);
    end
    check("settle_done", {31'd0, done_a}, 32'd1);
    step(1'b0);
    check("after_done_start", {31'd0, busy_a}, 32'd1);
    check("after_done_bouncy", {31'd0, bouncy_a}, 32'd0);
    for (int i = 0; i < B + S + 2; i++) step(1'b0);

    // A few more bursts for toggle-sequence coverage.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < B + S + 4; i++) step(r[0] ? 1'b0 : 1'b1);
    end

    // Reset mid-burst, asserted between edges.
    step(1'b1);
    for (int i = 0; i < 6; i++) step(1'b1);
    rst_n = 1'b0;
    level = 1'b0;
    #1;
    check_reset_lits("rst_mid");
    model_reset();
    @(posedge clk); #1;
    check_reset_lits("rst_mid_held");
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1'b0);
      check("no_resume", {31'd0, busy_a}, 32'd0);
    end

    // Final burst to 1 for the filter check.
    for (int i = 0; i < B + S + 4; i++) step(1'b1);
    check("filter_rises", fa_rises, fm_rises);
    check("filter_final", {31'd0, fa_st}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
